// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - round-robin two-requester APB master; optional ACCESS timeout via APB_ARB_TIMEOUT_EN
module apb_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [15:0] ERR_CODE = 16'h4552
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_i,
  input  logic [1:0]  write_i,
  input  logic [1:0]  tgt_i,
  input  logic [39:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [1:0]  err_o,
  output logic [15:0] rdata_o,
  output logic [1:0]  psel_s,
  output logic        penable_s,
  output logic        pwrite_s,
  output logic [1:0]  pstrb_s,
  output logic [19:0] paddr_s,
  output logic [15:0] pwdata_s,
  input  logic        pready_s,
  input  logic [15:0] prdata_s,
  input  logic        pslverr_s_rm,
  input  logic        pslverr_s_icn
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  state_t state_nxt;
  logic   last_gnt;    // index of the requester granted most recently
  logic   winner;      // index of the requester that wins in IDLE
  logic   timed_out;
  logic   access_end;
  logic   xfer_err;

  // Lone requester wins; on a tie the one not granted last wins
  assign winner = req_i[1] & (~req_i[0] | ~last_gnt);

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // Count ACCESS cycles without pready; held at zero outside ACCESS so entry starts from 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != ACCESS) begin
      to_cnt <= '0;
    end else if (!pready_s) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timed_out = (state == ACCESS) && !pready_s && (to_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timed_out      = 1'b0;
`endif

  assign access_end = pready_s | timed_out;
  // Only the selected target's slave error counts; a timeout is always an error
  assign xfer_err   = timed_out | (psel_s[1] ? pslverr_s_icn : pslverr_s_rm);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_i) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_end) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs, updated by the transition taken out of the current state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_o     <= '0;
      done_o    <= '0;
      err_o     <= '0;
      rdata_o   <= '0;
      psel_s    <= '0;
      penable_s <= 1'b0;
      pwrite_s  <= 1'b0;
      pstrb_s   <= '0;
      paddr_s   <= '0;
      pwdata_s  <= '0;
      last_gnt  <= 1'b1;
    end else begin
      done_o <= '0;
      err_o  <= '0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            gnt_o     <= winner ? 2'b10 : 2'b01;
            psel_s    <= tgt_i[winner] ? 2'b10 : 2'b01;
            penable_s <= 1'b0;
            pwrite_s  <= write_i[winner];
            pstrb_s   <= write_i[winner] ? 2'b11 : 2'b00;
            paddr_s   <= winner ? addr_i[39:20] : addr_i[19:0];
            pwdata_s  <= winner ? wdata_i[31:16] : wdata_i[15:0];
          end
        end
        SETUP: begin
          penable_s <= 1'b1;
        end
        ACCESS: begin
          if (access_end) begin
            psel_s    <= '0;
            penable_s <= 1'b0;
            done_o    <= gnt_o;
            if (xfer_err) begin
              err_o   <= gnt_o;
              rdata_o <= ERR_CODE;
            end else if (!pwrite_s) begin
              rdata_o <= prdata_s;
            end
          end
        end
        RESP: begin
          gnt_o    <= '0;
          last_gnt <= gnt_o[1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - self-checking bench for apb_arbiter
module tb_apb_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_i, write_i, tgt_i;
  logic [39:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  gnt_o, done_o, err_o;
  logic [15:0] rdata_o;
  logic [1:0]  psel_s;
  logic        penable_s, pwrite_s;
  logic [1:0]  pstrb_s;
  logic [19:0] paddr_s;
  logic [15:0] pwdata_s;
  logic        pready_s;
  logic [15:0] prdata_s;
  logic        pslverr_s_rm, pslverr_s_icn;

  apb_arbiter #(.TIMEOUT(4), .ERR_CODE(16'h4552)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .write_i(write_i), .tgt_i(tgt_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .psel_s(psel_s), .penable_s(penable_s), .pwrite_s(pwrite_s),
    .pstrb_s(pstrb_s), .paddr_s(paddr_s), .pwdata_s(pwdata_s), .pready_s(pready_s),
    .prdata_s(prdata_s), .pslverr_s_rm(pslverr_s_rm), .pslverr_s_icn(pslverr_s_icn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req, write, tgt;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    int          wait_n;
    logic [15:0] prdata;
    logic        rm_err, icn_err;
    logic [1:0]  e_gnt, e_psel, e_pstrb, e_err;
    logic        e_pwrite;
    logic [19:0] e_paddr;
    logic [15:0] e_pwdata, e_rdata;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference state: who was granted last, and what rdata_o should currently hold
  int          m_last  = 1;
  logic [15:0] m_rdata = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [1:0] req, write, tgt, input logic [19:0] a0, a1,
                               input logic [15:0] w0, w1, input int wn, input logic [15:0] prd,
                               input logic rme, icne, input logic [1:0] g, ps, st, er,
                               input logic pw, input logic [19:0] pa, input logic [15:0] pwd, rd);
    vec_t v;
    v.req = req; v.write = write; v.tgt = tgt; v.addr0 = a0; v.addr1 = a1;
    v.wdata0 = w0; v.wdata1 = w1; v.wait_n = wn; v.prdata = prd;
    v.rm_err = rme; v.icn_err = icne;
    v.e_gnt = g; v.e_psel = ps; v.e_pstrb = st; v.e_err = er; v.e_pwrite = pw;
    v.e_paddr = pa; v.e_pwdata = pwd; v.e_rdata = rd;
    return v;
  endfunction

  // Transfer-level reference: pick the winner, then derive what the APB side and the result must be
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   w;
    logic e;
    r = v;
    if (v.req == 2'b01) w = 0;
    else if (v.req == 2'b10) w = 1;
    else w = 1 - m_last;
    r.e_gnt    = (w == 1) ? 2'b10 : 2'b01;
    r.e_psel   = v.tgt[w] ? 2'b10 : 2'b01;
    r.e_pwrite = v.write[w];
    r.e_pstrb  = v.write[w] ? 2'b11 : 2'b00;
    r.e_paddr  = (w == 1) ? v.addr1 : v.addr0;
    r.e_pwdata = (w == 1) ? v.wdata1 : v.wdata0;
    e          = v.tgt[w] ? v.icn_err : v.rm_err;
    r.e_err    = e ? r.e_gnt : 2'b00;
    r.e_rdata  = e ? 16'h4552 : (v.write[w] ? m_rdata : v.prdata);
    return r;
  endfunction

  task automatic drive_idle();
    req_i = '0; write_i = '0; tgt_i = '0; addr_i = '0; wdata_i = '0;
    pready_s = 1'b0; prdata_s = '0; pslverr_s_rm = 1'b0; pslverr_s_icn = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    tick();
    reset = 1'b0;
    m_last  = 1;
    m_rdata = 16'h0;
  endtask

  // One full transfer from IDLE: request is pulled after SETUP and requester inputs are scrambled
  task automatic run(input vec_t v);
    req_i = v.req; write_i = v.write; tgt_i = v.tgt;
    addr_i = {v.addr1, v.addr0}; wdata_i = {v.wdata1, v.wdata0}; pready_s = 1'b0;
    tick();
    chk("setup_gnt", gnt_o, v.e_gnt);
    chk("setup_psel", psel_s, v.e_psel);
    chk("setup_penable", penable_s, 0);
    chk("setup_pwrite", pwrite_s, v.e_pwrite);
    chk("setup_pstrb", pstrb_s, v.e_pstrb);
    chk("setup_paddr", paddr_s, v.e_paddr);
    chk("setup_pwdata", pwdata_s, v.e_pwdata);
    chk("setup_done", done_o, 0);
    req_i = '0;
    write_i = 2'($urandom()); tgt_i = 2'($urandom());
    addr_i = {8'($urandom()), 32'($urandom())}; wdata_i = 32'($urandom());
    tick();
    for (int c = 0; c <= v.wait_n; c++) begin
      chk("access_penable", penable_s, 1);
      chk("access_psel", psel_s, v.e_psel);
      chk("access_paddr", paddr_s, v.e_paddr);
      chk("access_pwdata", pwdata_s, v.e_pwdata);
      chk("access_done", done_o, 0);
      if (c == v.wait_n) begin
        pready_s = 1'b1; prdata_s = v.prdata;
        pslverr_s_rm = v.rm_err; pslverr_s_icn = v.icn_err;
      end else begin
        pready_s = 1'b0; prdata_s = 16'($urandom());
        pslverr_s_rm = 1'($urandom()); pslverr_s_icn = 1'($urandom());
      end
      tick();
    end
    chk("resp_done", done_o, v.e_gnt);
    chk("resp_err", err_o, v.e_err);
    chk("resp_rdata", rdata_o, v.e_rdata);
    chk("resp_psel", psel_s, 0);
    chk("resp_penable", penable_s, 0);
    chk("resp_gnt", gnt_o, v.e_gnt);
    pready_s = 1'b0; pslverr_s_rm = 1'b0; pslverr_s_icn = 1'b0;
    tick();
    chk("idle_done", done_o, 0);
    chk("idle_err", err_o, 0);
    chk("idle_gnt", gnt_o, 0);
    chk("idle_rdata_hold", rdata_o, v.e_rdata);
    m_last  = (v.e_gnt == 2'b10) ? 1 : 0;
    m_rdata = v.e_rdata;
  endtask

  vec_t table_v[6];
  vec_t rv;
  int   order_q[$];
  int   when_q[$];
  int   exp_order[3];
  int   overlap, dbl, pen, seen;
  logic prev_done;
  logic [1:0] done_seen, err_seen;
  logic [15:0] rdata_seen;

  initial begin
    drive_idle();
    reset = 1'b1;
    #1;
    do_reset();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_psel", psel_s, 0);
    chk("rst_penable", penable_s, 0);
    chk("rst_pstrb", pstrb_s, 0);
    chk("rst_paddr", paddr_s, 0);

    //                req    write  tgt    addr0     addr1     wdata0    wdata1   wt prdata    rme  icne  gnt    psel   pstrb  err    pw   paddr     pwdata    rdata
    table_v[0] = mkv(2'b01, 2'b00, 2'b00, 20'h00010, 20'h00000, 16'h0000, 16'h0000, 0, 16'hBEEF, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 20'h00010, 16'h0000, 16'hBEEF);
    table_v[1] = mkv(2'b10, 2'b10, 2'b10, 20'h00000, 20'hABCDE, 16'h0000, 16'h1234, 0, 16'h7777, 1'b0, 1'b1, 2'b10, 2'b10, 2'b11, 2'b10, 1'b1, 20'hABCDE, 16'h1234, 16'h4552);
    table_v[2] = mkv(2'b10, 2'b10, 2'b10, 20'h00000, 20'hABCDE, 16'h0000, 16'h1234, 0, 16'h7777, 1'b1, 1'b0, 2'b10, 2'b10, 2'b11, 2'b00, 1'b1, 20'hABCDE, 16'h1234, 16'h4552);
    table_v[3] = mkv(2'b11, 2'b01, 2'b10, 20'h00001, 20'h33333, 16'h5A5A, 16'h6666, 2, 16'h8888, 1'b0, 1'b1, 2'b01, 2'b01, 2'b11, 2'b00, 1'b1, 20'h00001, 16'h5A5A, 16'h4552);
    table_v[4] = mkv(2'b11, 2'b00, 2'b10, 20'h44444, 20'hFFFFF, 16'h1111, 16'h9999, 1, 16'h1357, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 20'hFFFFF, 16'h9999, 16'h1357);
    table_v[5] = mkv(2'b01, 2'b00, 2'b00, 20'h12345, 20'h00000, 16'h2222, 16'h0000, 3, 16'hAAAA, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 20'h12345, 16'h2222, 16'h4552);
    for (int i = 0; i < 6; i++) run(table_v[i]);

    // Both requesters held high: back-to-back transfers alternating 0,1,0 at a 4-cycle period
    do_reset();
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
    req_i = 2'b11; write_i = 2'b00; tgt_i = 2'b00; addr_i = {20'h22222, 20'h11111};
    pready_s = 1'b1; prdata_s = 16'hC0DE;
    overlap = 0; dbl = 0; prev_done = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ($countones(gnt_o) > 1) overlap++;
      if (done_o != 2'b00) begin
        if (prev_done) dbl++;
        order_q.push_back(done_o == 2'b10 ? 1 : 0);
        when_q.push_back(c);
      end
      prev_done = (done_o != 2'b00);
    end
    req_i = 2'b00; pready_s = 1'b0;
    chk("tie_done_count", order_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < order_q.size()) begin
        chk("tie_order", order_q[i], exp_order[i]);
        chk("tie_done_cycle", when_q[i], 3 + 4 * i);
      end
    end
    chk("tie_gnt_overlap", overlap, 0);
    chk("tie_done_width", dbl, 0);
    tick();
    m_last = 0; m_rdata = 16'hC0DE;

    // Slave never ready
    req_i = 2'b01; write_i = 2'b00; tgt_i = 2'b00; addr_i = {20'h0, 20'h00ABC}; pready_s = 1'b0;
    tick();
    req_i = 2'b00;
    pen = 0; seen = 0; done_seen = '0; err_seen = '0; rdata_seen = '0;
`ifdef APB_ARB_TIMEOUT_EN
    for (int c = 0; c < 20 && seen == 0; c++) begin
      tick();
      if (penable_s) pen++;
      if (done_o != 2'b00) begin
        seen = 1; done_seen = done_o; err_seen = err_o; rdata_seen = rdata_o;
      end
    end
    chk("to_penable_cycles", pen, 4);
    chk("to_done", done_seen, 2'b01);
    chk("to_err", err_seen, 2'b01);
    chk("to_rdata", rdata_seen, 16'h4552);
    tick();
    m_last = 0; m_rdata = 16'h4552;
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      if (done_o != 2'b00) seen++;
    end
    chk("no_timeout_done", seen, 0);
    chk("no_timeout_penable", penable_s, 1);
    pready_s = 1'b1; prdata_s = 16'h0F1E;
    tick();
    chk("no_timeout_late_done", done_o, 2'b01);
    chk("no_timeout_late_rdata", rdata_o, 16'h0F1E);
    pready_s = 1'b0;
    tick();
    m_last = 0; m_rdata = 16'h0F1E;
`endif

    // Randomised transfers against the reference
    for (int i = 0; i < 40; i++) begin
      rv.req = 2'($urandom_range(1, 3)); rv.write = 2'($urandom()); rv.tgt = 2'($urandom());
      rv.addr0 = 20'($urandom()); rv.addr1 = 20'($urandom());
      rv.wdata0 = 16'($urandom()); rv.wdata1 = 16'($urandom());
      rv.wait_n = $urandom_range(0, 3); rv.prdata = 16'($urandom());
      rv.rm_err = 1'($urandom()); rv.icn_err = 1'($urandom());
      rv = model(rv);
      run(rv);
    end

    // Reset during ACCESS abandons the transfer; a pending req1 then goes first
    req_i = 2'b01; write_i = 2'b01; tgt_i = 2'b00;
    addr_i = {20'h0, 20'h0F0F0}; wdata_i = {16'h0, 16'hA5A5}; pready_s = 1'b0;
    tick();
    req_i = 2'b10;
    tick();
    chk("mid_penable", penable_s, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_psel", psel_s, 0);
    chk("mid_rst_penable", penable_s, 0);
    chk("mid_rst_pwrite", pwrite_s, 0);
    chk("mid_rst_pstrb", pstrb_s, 0);
    chk("mid_rst_paddr", paddr_s, 0);
    chk("mid_rst_pwdata", pwdata_s, 0);
    chk("mid_rst_gnt", gnt_o, 0);
    chk("mid_rst_rdata", rdata_o, 0);
    tick();
    chk("mid_rst_done", done_o, 0);
    reset = 1'b0;
    m_last = 1; m_rdata = 16'h0;
    rv = mkv(2'b10, 2'b00, 2'b01, 20'h0F0F0, 20'h5A5A5, 16'h0, 16'h0, 0, 16'h3C3C, 1'b0, 1'b0,
             2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 20'h0, 16'h0, 16'h0);
    rv = model(rv);
    run(rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
